// File: rtl/lram_writer.sv
// lram_writer: 64x8 LUT RAM writer with full-memory clear sweep and write counter.
// Define LRAM_WRITER_READBACK_EN to add a one-cycle readback check after every accepted write.
module lram_writer #(
    parameter logic [7:0] CLEAR_VAL = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_addr,
    input  logic [7:0]  in_data,
    input  logic [5:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        clear_done,
    output logic [15:0] wr_count,
    output logic        err
);
`ifdef LRAM_WRITER_READBACK_EN
    typedef enum logic [1:0] {IDLE, CLEAR, CHECK} state_t;
    logic [5:0] cap_addr;
    logic [7:0] cap_data;
`else
    typedef enum logic [1:0] {IDLE, CLEAR} state_t;
    assign err = 1'b0;
`endif
    state_t     state;
    logic [5:0] cnt;
    logic [7:0] mem [64];
    logic       hs;
    logic       we;
    logic [5:0] wa;
    logic [7:0] wd;

    // Gating with reset keeps the port closed while the block is held in reset.
    assign in_ready = reset && state == IDLE && !clear;
    assign hs       = in_valid && in_ready;
    assign busy     = state != IDLE;
    assign rd_data  = mem[rd_addr];

    always_comb begin
        we = hs || state == CLEAR;
        wa = state == CLEAR ? cnt : in_addr;
        wd = state == CLEAR ? CLEAR_VAL : in_data;
    end

    always_ff @(posedge clock) begin
        if (we) mem[wa] <= wd;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 6'd0;
            wr_count   <= 16'd0;
            clear_done <= 1'b0;
`ifdef LRAM_WRITER_READBACK_EN
            err        <= 1'b0;
            cap_addr   <= 6'd0;
            cap_data   <= 8'd0;
`endif
        end else begin
            clear_done <= 1'b0;
            if (hs) wr_count <= wr_count + 16'd1;
            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= CLEAR;
                        cnt   <= 6'd0;
                    end
`ifdef LRAM_WRITER_READBACK_EN
                    else if (hs) begin
                        state    <= CHECK;
                        cap_addr <= in_addr;
                        cap_data <= in_data;
                    end
`endif
                end
                CLEAR: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd63) begin
                        state      <= IDLE;
                        clear_done <= 1'b1;
                    end
                end
`ifdef LRAM_WRITER_READBACK_EN
                CHECK: begin
                    if (mem[cap_addr] != cap_data) err <= 1'b1;
                    state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
